// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle between instruction fetch, the fetch queue
// and decode.
//   push_valid/push_ready/push_pc/push_inst : fetch -> queue entry handshake
//   pop_valid/pop_ready/pop_pc/pop_inst     : queue -> decode head handshake
//   flush                                   : redirect, drop everything queued
//   count                                   : current occupancy
// Modports:
//   slave  - the queue itself
//   master - the surrounding pipeline (fetch + decode + redirect logic)
interface fetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic                       push_valid;
  logic                       push_ready;
  logic [ADDR_W-1:0]          push_pc;
  logic [INST_W-1:0]          push_inst;
  logic                       pop_valid;
  logic                       pop_ready;
  logic [ADDR_W-1:0]          pop_pc;
  logic [INST_W-1:0]          pop_inst;
  logic                       flush;
  logic [$clog2(DEPTH):0]     count;

  modport slave (
    input  push_valid, push_pc, push_inst, pop_ready, flush,
    output push_ready, pop_valid, pop_pc, pop_inst, count
  );

  modport master (
    output push_valid, push_pc, push_inst, pop_ready, flush,
    input  push_ready, pop_valid, pop_pc, pop_inst, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: first-word-fall-through FIFO of {pc, instruction} pairs that
// decouples the fetch path from a stalling decode stage.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears pointers and occupancy)
//   bus   - fetch_queue_if.slave: push side (fetch), pop side (decode),
//           flush (redirect) and count (occupancy)
// DEPTH must be a power of two >= 2 so the pointers wrap for free.
module fetch_queue #(
  parameter int              DEPTH  = 4,
  parameter int              ADDR_W = 32,
  parameter int              INST_W = 32,
  parameter logic [INST_W-1:0] NOP  = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  logic push_ready;
  logic pop_valid;
  logic push_fire;
  logic pop_fire;

  // Ready comes from registered occupancy only, so pop_ready never reaches
  // push_ready combinationally; a full queue stays closed even while popping.
  assign push_ready = (count_reg < CNT_W'(DEPTH));
  assign pop_valid  = (count_reg != '0);

  // A flush cancels both transfers in its cycle.
  assign push_fire = bus.push_valid & push_ready & ~bus.flush;
  assign pop_fire  = pop_valid & bus.pop_ready & ~bus.flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (bus.flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({push_fire, pop_fire})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; stale slots are never visible because the
  // head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      pc_mem[wr_ptr_reg]   <= bus.push_pc;
      inst_mem[wr_ptr_reg] <= bus.push_inst;
    end
  end

  // First-word-fall-through head; an empty queue presents a NOP at pc 0.
  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_pc     = pop_valid ? pc_mem[rd_ptr_reg]   : '0;
  assign bus.pop_inst   = pop_valid ? inst_mem[rd_ptr_reg] : NOP;
  assign bus.count      = count_reg;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk;
  logic rst_n;

  fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .INST_W(32), .NOP(NOP)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pr;
    logic        fl;
    int          e_cnt;
    logic        e_pv;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_rdy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: an ordered list of {pc, inst} pairs.
  logic [63:0] model_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                       input logic pr, input logic fl);
    bus.push_valid = pv;
    bus.push_pc    = pc;
    bus.push_inst  = inst;
    bus.pop_ready  = pr;
    bus.flush      = fl;
  endtask

  task automatic add(input logic pv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic pr, input logic fl, input int e_cnt, input logic e_pv,
                     input logic [31:0] e_pc, input logic [31:0] e_inst, input logic e_rdy);
    vec_t v;
    v.pv = pv; v.pc = pc; v.inst = inst; v.pr = pr; v.fl = fl;
    v.e_cnt = e_cnt; v.e_pv = e_pv; v.e_pc = e_pc; v.e_inst = e_inst; v.e_rdy = e_rdy;
    tbl.push_back(v);
  endtask

  task automatic check_model(input string tag);
    int          sz;
    logic [31:0] e_pc, e_inst;
    sz     = model_q.size();
    e_pc   = (sz != 0) ? model_q[0][63:32] : 32'h0;
    e_inst = (sz != 0) ? model_q[0][31:0]  : NOP;
    chk({tag, ".count"},      32'(bus.count),      32'(sz));
    chk({tag, ".pop_valid"},  32'(bus.pop_valid),  32'(sz != 0));
    chk({tag, ".pop_pc"},     bus.pop_pc,          e_pc);
    chk({tag, ".pop_inst"},   bus.pop_inst,        e_inst);
    chk({tag, ".push_ready"}, 32'(bus.push_ready), 32'(sz < DEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // 1. Reset then idle
    rst_n = 1'b0;
    tick();
    tick();
    #4 rst_n = 1'b1;
    tick();
    chk("rst.push_ready", 32'(bus.push_ready), 32'h1);
    chk("rst.pop_valid",  32'(bus.pop_valid),  32'h0);
    chk("rst.count",      32'(bus.count),      32'h0);
    chk("rst.pop_inst",   bus.pop_inst,        NOP);
    chk("rst.pop_pc",     bus.pop_pc,          32'h0);
    $display("txn reset: count=%0d pop_valid=%0b", bus.count, bus.pop_valid);

    // 2. fill/drain, 4. full with pop, 5. flush with push
    add(1, 32'h00,  32'hA0, 0, 0, 1, 1, 32'h00,  32'hA0, 1);
    add(1, 32'h04,  32'hA1, 0, 0, 2, 1, 32'h00,  32'hA0, 1);
    add(1, 32'h08,  32'hA2, 0, 0, 3, 1, 32'h00,  32'hA0, 1);
    add(1, 32'h0C,  32'hA3, 0, 0, 4, 1, 32'h00,  32'hA0, 0);
    add(1, 32'h10,  32'hA4, 0, 0, 4, 1, 32'h00,  32'hA0, 0);
    add(0, 32'h00,  32'h00, 1, 0, 3, 1, 32'h04,  32'hA1, 1);
    add(0, 32'h00,  32'h00, 1, 0, 2, 1, 32'h08,  32'hA2, 1);
    add(0, 32'h00,  32'h00, 1, 0, 1, 1, 32'h0C,  32'hA3, 1);
    add(0, 32'h00,  32'h00, 1, 0, 0, 0, 32'h00,  NOP,    1);
    add(0, 32'h00,  32'h00, 1, 0, 0, 0, 32'h00,  NOP,    1);
    add(1, 32'h100, 32'hB0, 0, 0, 1, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h104, 32'hB1, 0, 0, 2, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h108, 32'hB2, 0, 0, 3, 1, 32'h100, 32'hB0, 1);
    add(1, 32'h10C, 32'hB3, 0, 0, 4, 1, 32'h100, 32'hB0, 0);
    add(1, 32'h110, 32'hB4, 1, 0, 3, 1, 32'h104, 32'hB1, 1);
    add(1, 32'h40,  32'hE0, 1, 1, 0, 0, 32'h00,  NOP,    1);
    add(1, 32'h80,  32'hC0, 0, 0, 1, 1, 32'h80,  32'hC0, 1);
    add(0, 32'h00,  32'h00, 1, 0, 0, 0, 32'h00,  NOP,    1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].pv, tbl[i].pc, tbl[i].inst, tbl[i].pr, tbl[i].fl);
      tick();
      chk($sformatf("vec%0d.count", i),      32'(bus.count),      32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.pop_valid", i),  32'(bus.pop_valid),  32'(tbl[i].e_pv));
      chk($sformatf("vec%0d.pop_pc", i),     bus.pop_pc,          tbl[i].e_pc);
      chk($sformatf("vec%0d.pop_inst", i),   bus.pop_inst,        tbl[i].e_inst);
      chk($sformatf("vec%0d.push_ready", i), 32'(bus.push_ready), 32'(tbl[i].e_rdy));
      $display("txn vec%0d: pv=%0b pc=%0h pr=%0b fl=%0b -> count=%0d head=%0h",
               i, tbl[i].pv, tbl[i].pc, tbl[i].pr, tbl[i].fl, bus.count, bus.pop_pc);
    end

    // 3. Streaming: one entry in flight, pointers wrap past DEPTH
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'(i * 4), 32'(32'hD0 + i), 1'b1, 1'b0);
      tick();
      chk($sformatf("stream%0d.count", i),  32'(bus.count), 32'h1);
      chk($sformatf("stream%0d.pop_pc", i), bus.pop_pc,     32'(i * 4));
      chk($sformatf("stream%0d.inst", i),   bus.pop_inst,   32'(32'hD0 + i));
      $display("txn stream%0d: head=%0h count=%0d", i, bus.pop_pc, bus.count);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("stream.drain", 32'(bus.count), 32'h0);

    // 6. Asynchronous reset mid-stream
    drive(1'b1, 32'h200, 32'hF0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h204, 32'hF1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("arst.pre_count", 32'(bus.count), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.count",     32'(bus.count),     32'h0);
    chk("arst.pop_valid", 32'(bus.pop_valid), 32'h0);
    chk("arst.pop_inst",  bus.pop_inst,       NOP);
    $display("txn async reset: count=%0d pop_valid=%0b", bus.count, bus.pop_valid);
    tick();
    tick();
    #3 rst_n = 1'b1;
    tick();
    chk("arst.push_ready", 32'(bus.push_ready), 32'h1);
    chk("arst.idle_count", 32'(bus.count),      32'h0);

    // Randomized traffic against the list model
    model_q.delete();
    for (int i = 0; i < 400; i++) begin
      logic        pv, pr, fl, rdy;
      logic [31:0] pc, inst;
      pv   = 1'($urandom_range(0, 3) != 0);
      pr   = 1'($urandom_range(0, 2) != 0);
      fl   = 1'($urandom_range(0, 15) == 0);
      pc   = $urandom & 32'hFFFF_FFFC;
      inst = $urandom;
      drive(pv, pc, inst, pr, fl);
      rdy = (model_q.size() < DEPTH);
      if (fl) begin
        model_q.delete();
      end else begin
        if (pr && model_q.size() != 0) void'(model_q.pop_front());
        if (pv && rdy) model_q.push_back({pc, inst});
      end
      tick();
      check_model($sformatf("rnd%0d", i));
      $display("txn rnd%0d: pv=%0b pr=%0b fl=%0b -> count=%0d", i, pv, pr, fl, bus.count);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small FIFO between the PC/instruction-memory fetch path and the decode stage.
- Buffers fetched {pc, instruction} pairs so fetch can keep issuing while decode stalls.
- Drops all buffered entries on a redirect (branch/jal taken) flush.
- Ready/valid handshake on both sides; first-word-fall-through output.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2
- ADDR_W, 32, PC width
- INST_W, 32, instruction width
- NOP, 32'h00000013, instruction word driven on pop_inst when the queue is empty (addi x0,x0,0)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- push_valid  in  1  fetch side presents a valid {push_pc, push_inst}
- push_ready  out  1  queue can accept an entry this cycle
- push_pc  in  ADDR_W  PC of the fetched instruction
- push_inst  in  INST_W  fetched instruction word
- pop_valid  out  1  head entry is valid
- pop_ready  in  1  decode consumes the head this cycle
- pop_pc  out  ADDR_W  head PC
- pop_inst  out  INST_W  head instruction
- flush  in  1  discard all entries (redirect)
- count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately clears wr_ptr, rd_ptr and count to 0. Outputs then read push_ready=1, pop_valid=0, pop_pc=0, pop_inst=NOP. Storage contents need not be reset.
- Accept: push_fire = push_valid & push_ready. Pop: pop_fire = pop_valid & pop_ready.
- push_ready = (count < DEPTH), decoded from registered count only. It does not depend on pop_ready, so there is no combinational path from decode to fetch. When the queue is full, a same-cycle pop does not enable a push.
- pop_valid = (count != 0).
- When pop_valid=1, pop_pc and pop_inst = storage[rd_ptr] (FWFT). When pop_valid=0, they are 0 and NOP.
- Entry latency: an entry pushed at edge N is visible at the head after edge N if the queue was empty. There is no same-cycle bypass from push to pop.
- Per clock edge, with flush=0:
  - push_fire: write storage[wr_ptr], then wr_ptr+1.
  - pop_fire: rd_ptr+1.
  - count += push_fire - pop_fire. Simultaneous push and pop leaves count unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally.
- flush=1 is synchronous and has highest priority. At the edge, wr_ptr, rd_ptr and count go to 0. Any push or pop in that cycle is ignored: the entry is not stored and no pop is counted. The next cycle shows pop_valid=0 and push_ready=1.
- push_valid while full: no write, no pointer change. Fetch must hold its data.
- pop_ready while empty: no effect.
- count never exceeds DEPTH and never underflows.
- Reset asserted mid-operation overrides everything, including flush. Contents are lost.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then release -> push_ready=1, pop_valid=0, count=0, pop_inst=32'h00000013, pop_pc=0.
2. Fill and drain: push PCs 0x0, 0x4, 0x8, 0xC with insts 0xA0..0xA3 while pop_ready=0 -> count=4, push_ready=0. A 5th push of 0x10 is not accepted. Then pop_ready=1 for 4 cycles -> pop_pc sequence 0x0, 0x4, 0x8, 0xC; count ends at 0.
3. Streaming: push_valid=1 and pop_ready=1 continuously for 10 cycles, PCs 0x0..0x24 -> count stays 1 after the first edge. Pop order matches push order, confirming pointer wrap past DEPTH.
4. Full with simultaneous pop: queue full, push_valid=1, pop_ready=1 -> pop of the head occurs, push not accepted, count=3 next cycle.
5. Flush with push: queue holds 3 entries; assert flush with push_valid=1 (pc 0x40) -> next cycle count=0, pop_valid=0. Next push of 0x80 appears at the head with pop_pc=0x80.
6. Asynchronous reset mid-stream: drop rst_n between clock edges while count=2 -> count=0 and pop_valid=0 immediately, without waiting for a clock edge.
